// File: rtl/fc_neuron_if.sv
// Port bundle for the fully-connected neuron engine: control handshake,
// layer-1 read port, weight ROM port and result write port.
interface fc_neuron_if;
   localparam int unsigned DATA_W  = 20;
   localparam int unsigned RADDR_W = 10;
   localparam int unsigned WADDR_W = 13;
   localparam int unsigned OADDR_W = 12;
   localparam int unsigned SEL_W   = 3;

   logic               start;
   logic               relu_en;
   logic [DATA_W-1:0]  bias;
   logic               crd;
   logic [RADDR_W-1:0] caddr_rd;
   logic [DATA_W-1:0]  cdata_rd;
   logic [WADDR_W-1:0] waddr;
   logic [DATA_W-1:0]  wdata;
   logic               cwr;
   logic [OADDR_W-1:0] caddr_wr;
   logic [DATA_W-1:0]  cdata_wr;
   logic [SEL_W-1:0]   csel;
   logic               busy;
   logic               done;

   modport master (
      output start, relu_en, bias, cdata_rd, wdata,
      input  crd, caddr_rd, waddr, cwr, caddr_wr, cdata_wr, csel, busy, done
   );

   modport slave (
      input  start, relu_en, bias, cdata_rd, wdata,
      output crd, caddr_rd, waddr, cwr, caddr_wr, cdata_wr, csel, busy, done
   );
endinterface

// File: rtl/fc_neuron.sv
// Fully-connected layer engine: for each of NOUT neurons, dot-product the
// 1024-pixel pooled map with that neuron's weights, add bias, round, clamp.
module fc_neuron #(
   parameter int unsigned NOUT = 4
) (
   input logic        clk,
   input logic        reset,
   fc_neuron_if.slave bus
);
   localparam int unsigned DW     = 20;
   localparam int unsigned PIX_W  = 10;
   localparam int unsigned N_W    = 3;
   localparam int unsigned PROD_W = 40;
   localparam int unsigned ACC_W  = 50;
   localparam int unsigned HI_W   = 35;
   localparam int unsigned OA_W   = 12;
   localparam int unsigned SEL_W  = 3;

   localparam logic [PIX_W-1:0] LAST_PIX = '1;
   localparam logic [N_W-1:0]   LAST_N   = N_W'(NOUT - 1);
   localparam logic [SEL_W-1:0] SEL_RD   = 3'b011;
   localparam logic [SEL_W-1:0] SEL_WR   = 3'b101;
   localparam logic [DW-1:0]    SAT_POS  = 20'h7FFFF;
   localparam logic [DW-1:0]    SAT_NEG  = 20'h80000;

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, ROUND, WRITE, FIN} state_t;

   state_t state, state_nx;

   logic [N_W-1:0]           n, n_d;
   logic                     dv;
   logic [ACC_W-1:0]         acc;
   logic [DW-1:0]            bias_q;
   logic                     relu_q;
   logic signed [PROD_W-1:0] prod;
   logic [HI_W-1:0]          sum_hi;
   logic [DW-1:0]            result;

   logic                     crd_d, cwr_d, busy_d, done_d;
   logic [PIX_W-1:0]         caddr_rd_d;
   logic [PIX_W+N_W-1:0]     waddr_d;
   logic [OA_W-1:0]          caddr_wr_d;
   logic [DW-1:0]            cdata_wr_d;
   logic [SEL_W-1:0]         csel_d;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; start only matters in IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (bus.caddr_rd == LAST_PIX) state_nx = DRAIN;
         DRAIN:   state_nx = ROUND;
         ROUND:   state_nx = WRITE;
         WRITE:   state_nx = (n == LAST_N) ? FIN : RUN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Round-half-up of acc/2^16 plus bias: the +2^15 term reduces to a carry of acc[15]
   always_comb begin
      prod   = PROD_W'($signed(bus.cdata_rd)) * PROD_W'($signed(bus.wdata));
      sum_hi = {acc[ACC_W-1], acc[ACC_W-1:16]}
             + {{(HI_W-DW){bias_q[DW-1]}}, bias_q}
             + HI_W'(acc[15]);
      if (sum_hi[HI_W-1:DW-1] != {(HI_W-DW+1){sum_hi[HI_W-1]}})
         result = sum_hi[HI_W-1] ? SAT_NEG : SAT_POS;
      else
         result = sum_hi[DW-1:0];
      if (relu_q && result[DW-1]) result = '0;
   end

   // Output logic: values each registered output takes in the coming state
   always_comb begin
      crd_d      = 1'b0;
      cwr_d      = 1'b0;
      csel_d     = '0;
      busy_d     = (state_nx != IDLE);
      done_d     = (state == FIN);
      n_d        = n;
      caddr_rd_d = bus.caddr_rd;
      waddr_d    = bus.waddr;
      caddr_wr_d = bus.caddr_wr;
      cdata_wr_d = bus.cdata_wr;
      case (state_nx)
         RUN: begin
            crd_d  = 1'b1;
            csel_d = SEL_RD;
            if (state == IDLE)       n_d = '0;
            else if (state == WRITE) n_d = n + N_W'(1);
            caddr_rd_d = (state == RUN) ? bus.caddr_rd + PIX_W'(1) : '0;
            waddr_d    = {n_d, caddr_rd_d};
         end
         DRAIN: csel_d = SEL_RD;
         WRITE: begin
            cwr_d      = 1'b1;
            csel_d     = SEL_WR;
            caddr_wr_d = OA_W'(n);
            cdata_wr_d = result;
         end
         default: ;
      endcase
   end

   // Output and neuron-index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n            <= '0;
         bus.crd      <= 1'b0;
         bus.cwr      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.caddr_rd <= '0;
         bus.waddr    <= '0;
         bus.caddr_wr <= '0;
         bus.cdata_wr <= '0;
         bus.csel     <= '0;
      end else begin
         n            <= n_d;
         bus.crd      <= crd_d;
         bus.cwr      <= cwr_d;
         bus.busy     <= busy_d;
         bus.done     <= done_d;
         bus.caddr_rd <= caddr_rd_d;
         bus.waddr    <= waddr_d;
         bus.caddr_wr <= caddr_wr_d;
         bus.cdata_wr <= cdata_wr_d;
         bus.csel     <= csel_d;
      end
   end

   // Datapath: memory data lands one cycle after its strobe, so MAC follows crd by one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dv     <= 1'b0;
         acc    <= '0;
         bias_q <= '0;
         relu_q <= 1'b0;
      end else begin
         dv <= bus.crd;
         if (state != RUN && state_nx == RUN)
            acc <= '0;
         else if (dv)
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
         if (state == IDLE && bus.start) begin
            bias_q <= bus.bias;
            relu_q <= bus.relu_en;
         end
      end
   end
endmodule

// File: tb/tb_fc_neuron.sv
// Self-checking bench for fc_neuron: directed vector table, random passes
// against an arithmetic reference model, busy-restart and mid-pass reset.
module tb_fc_neuron;
   localparam int NOUT = 4;
   localparam int LAT  = 1027 * NOUT + 1;

   logic clk;
   logic reset;
   fc_neuron_if bus ();

   fc_neuron #(.NOUT(NOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [19:0] pix_mem [1024];
   logic [19:0] w_mem   [8192];
   logic [19:0] exp_res [NOUT];

   // Layer-1 memory and weight ROM, one cycle read latency
   always @(posedge clk) begin
      bus.cdata_rd <= pix_mem[bus.caddr_rd];
      bus.wdata    <= w_mem[bus.waddr];
   end

   // Bus monitor: records writes and counts protocol violations
   logic [11:0] wr_addr [$];
   logic [19:0] wr_data [$];
   int          proto_err = 0;
   logic [9:0]  exp_pix;
   logic [2:0]  pass_wr;
   always @(negedge clk) begin
      if (reset || !bus.busy) begin
         exp_pix = '0;
         pass_wr = '0;
      end
      if (!reset) begin
         if (bus.crd) begin
            if (bus.cwr || !bus.busy || bus.csel != 3'b011 || bus.caddr_rd != exp_pix
                || bus.waddr != {pass_wr, exp_pix})
               proto_err++;
            exp_pix = exp_pix + 10'd1;
         end
         if (bus.cwr) begin
            if (bus.csel != 3'b101) proto_err++;
            wr_addr.push_back(bus.caddr_wr);
            wr_data.push_back(bus.cdata_wr);
            pass_wr = pass_wr + 3'd1;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".crd"},      32'(bus.crd), 0);
      check({tag, ".cwr"},      32'(bus.cwr), 0);
      check({tag, ".busy"},     32'(bus.busy), 0);
      check({tag, ".done"},     32'(bus.done), 0);
      check({tag, ".caddr_rd"}, 32'(bus.caddr_rd), 0);
      check({tag, ".waddr"},    32'(bus.waddr), 0);
      check({tag, ".caddr_wr"}, 32'(bus.caddr_wr), 0);
      check({tag, ".cdata_wr"}, 32'(bus.cdata_wr), 0);
      check({tag, ".csel"},     32'(bus.csel), 0);
   endtask

   // Reference: exact integer dot product, then round/saturate/ReLU from the rules
   function automatic logic [19:0] model(input int n, input logic [19:0] b, input bit relu);
      longint acc = 0;
      longint q;
      for (int p = 0; p < 1024; p++)
         acc += longint'($signed(pix_mem[p])) * longint'($signed(w_mem[n * 1024 + p]));
      q = (acc + longint'($signed(b)) * 65536 + 32768) >>> 16;
      if (q > 524287)  q = 524287;
      if (q < -524288) q = -524288;
      if (relu && q < 0) q = 0;
      return q[19:0];
   endfunction

   task automatic fill(input logic [19:0] p0, input logic [19:0] prest,
                       input logic [19:0] w0, input logic [19:0] wrest);
      for (int p = 0; p < 1024; p++) pix_mem[p] = (p == 0) ? p0 : prest;
      for (int i = 0; i < 8192; i++) w_mem[i] = (i % 1024 == 0) ? w0 : wrest;
   endtask

   task automatic fill_random(input int pm, input int wm);
      int v;
      for (int p = 0; p < 1024; p++) begin
         v = int'($urandom_range(0, 2 * pm)) - pm;
         pix_mem[p] = v[19:0];
      end
      for (int i = 0; i < 8192; i++) begin
         v = int'($urandom_range(0, 2 * wm)) - wm;
         w_mem[i] = v[19:0];
      end
   endtask

   // One full pass; bias/relu_en are scrambled mid-pass to prove they were captured
   task automatic run_pass(input string tag, input logic [19:0] b, input bit relu, input int extra);
      int base, perr0, cycles, cnt;
      base  = wr_data.size();
      perr0 = proto_err;
      @(negedge clk);
      bus.bias = b; bus.relu_en = relu; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < LAT + 50) begin
         @(posedge clk); #1;
         cycles++;
         bus.start = (extra > 0) && (cycles == extra || cycles == extra + 1000);
         if (cycles == 2) begin bus.bias = ~b; bus.relu_en = ~relu; end
      end
      bus.start = 1'b0;
      check({tag, ".latency"}, 32'(cycles), 32'(LAT));
      check({tag, ".busy_at_done"}, 32'(bus.busy), 0);
      @(posedge clk); #1;
      check({tag, ".done_width"}, 32'(bus.done), 0);
      cnt = wr_data.size() - base;
      check({tag, ".writes"}, 32'(cnt), 32'(NOUT));
      for (int i = 0; i < NOUT && i < cnt; i++) begin
         check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[base + i]), 32'(i));
         check($sformatf("%s.data%0d", tag, i), 32'(wr_data[base + i]), 32'(exp_res[i]));
      end
      check({tag, ".protocol"}, 32'(proto_err - perr0), 0);
   endtask

   typedef struct {
      logic [19:0] p0, prest, w0, wrest, b;
      bit          relu;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int base;
      logic [19:0] rb;
      bit rr;

      vecs[0] = '{20'h10000, 20'h10000, 20'h00040, 20'h00040, 20'h00000, 1'b0, 20'h10000};
      vecs[1] = '{20'h10000, 20'h10000, 20'hFFFC0, 20'hFFFC0, 20'h00000, 1'b1, 20'h00000};
      vecs[2] = '{20'h10000, 20'h10000, 20'hFFFC0, 20'hFFFC0, 20'h00000, 1'b0, 20'hF0000};
      vecs[3] = '{20'h00001, 20'h00000, 20'h08000, 20'h00000, 20'h00000, 1'b0, 20'h00001};
      vecs[4] = '{20'h00001, 20'h00000, 20'h07FFF, 20'h00000, 20'h00000, 1'b0, 20'h00000};
      vecs[5] = '{20'h70000, 20'h70000, 20'h10000, 20'h10000, 20'h00000, 1'b0, 20'h7FFFF};
      vecs[6] = '{20'h70000, 20'h70000, 20'hF0000, 20'hF0000, 20'h00000, 1'b0, 20'h80000};
      vecs[7] = '{20'h00000, 20'h00000, 20'h12345, 20'h12345, 20'h01310, 1'b0, 20'h01310};
      vecs[8] = '{20'h00000, 20'h00000, 20'h12345, 20'h12345, 20'hF0000, 1'b1, 20'h00000};

      reset = 1'b1;
      bus.start = 1'b0; bus.relu_en = 1'b0; bus.bias = '0;
      fill(20'h0, 20'h0, 20'h0, 20'h0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         fill(vecs[i].p0, vecs[i].prest, vecs[i].w0, vecs[i].wrest);
         for (int n = 0; n < NOUT; n++) exp_res[n] = vecs[i].exp;
         run_pass($sformatf("vec%0d", i), vecs[i].b, vecs[i].relu, 0);
      end

      for (int r = 0; r < 3; r++) begin
         if (r == 2) fill_random(20'h7FFFF, 20'h7FFFF);
         else        fill_random(20'h3FFF, 20'h3FF);
         rb = 20'($urandom_range(0, 20'hFFFFF));
         rr = 1'($urandom_range(0, 1));
         if (r == 0) rb = 20'($signed(rb) >>> 4);
         for (int n = 0; n < NOUT; n++) exp_res[n] = model(n, rb, rr);
         run_pass($sformatf("rand%0d", r), rb, rr, 0);
      end

      fill(20'h10000, 20'h10000, 20'h00040, 20'h00040);
      for (int n = 0; n < NOUT; n++) exp_res[n] = 20'h10000;
      run_pass("restart_ignored", 20'h0, 1'b0, 100);

      base = wr_data.size();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (500) @(posedge clk);
      #1 reset = 1'b1;
      #1 check_reset_vals("midreset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (1300) @(posedge clk);
      #1;
      check("midreset.no_write", 32'(wr_data.size() - base), 0);
      check("midreset.idle_busy", 32'(bus.busy), 0);
      run_pass("after_reset", 20'h0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
